// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: streams the input RAM into the Sobel kernel in raster order and
// writes kernel results to the output RAM. Define SOBEL_FRAME_CTRL_PERF_EN to add cyc_cnt_o.
module sobel_frame_ctrl #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int ADDR_W   = 12,
  parameter int DRAIN_TO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pause_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic [7:0]        pix_o,
  output logic              pix_valid_o,
  input  logic [7:0]        k_gray_i,
  input  logic              k_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef SOBEL_FRAME_CTRL_PERF_EN
  ,
  output logic [31:0]       cyc_cnt_o
`endif
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = (IMG_W - 2) * (IMG_H - 2);
  localparam int IDLE_W = $clog2(DRAIN_TO + 1);

  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] NOUT_A  = ADDR_W'(NOUT);
  localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(DRAIN_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] wr_cnt_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              wr_en_reg;
  logic [7:0]        pix_reg;
  logic              pix_valid_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic in_frame;
  logic fetch_go;
  logic wr_go;

  always_comb begin
    in_frame = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
    fetch_go = (state_reg == S_FETCH) && !pause_i;
    wr_go    = in_frame && k_valid_i && (wr_cnt_reg < NOUT_A);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rd_addr_reg   <= '0;
      wr_cnt_reg    <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_en_reg     <= 1'b0;
      pix_reg       <= '0;
      pix_valid_reg <= 1'b0;
      idle_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // RAM data for a fetch arrives one cycle after the read strobe.
      pix_valid_reg <= fetch_go;
      pix_reg       <= rd_data_i;

      wr_en_reg <= wr_go;
      if (wr_go) begin
        wr_addr_reg <= wr_cnt_reg;
        wr_data_reg <= k_gray_i;
        wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      end

      done_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            state_reg    <= S_FETCH;
            busy_reg     <= 1'b1;
            err_reg      <= 1'b0;
            rd_addr_reg  <= '0;
            wr_cnt_reg   <= '0;
            idle_cnt_reg <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_go) begin
            if (rd_addr_reg == LAST_RD) begin
              state_reg    <= S_DRAIN;
              idle_cnt_reg <= '0;
            end else begin
              rd_addr_reg <= rd_addr_reg + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Completion outranks timeout so a finished frame never reports err_o.
          if (wr_cnt_reg == NOUT_A) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else if (k_valid_i) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == TO_LAST) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SOBEL_FRAME_CTRL_PERF_EN
  logic [31:0] cyc_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE) && start_i) begin
      cyc_cnt_reg <= '0;
    end else if (busy_reg) begin
      cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
    end
  end

  assign cyc_cnt_o = cyc_cnt_reg;
`endif

  assign rd_en_o     = fetch_go;
  assign rd_addr_o   = rd_addr_reg;
  assign pix_o       = pix_reg;
  assign pix_valid_o = pix_valid_reg;
  assign wr_en_o     = wr_en_reg;
  assign wr_addr_o   = wr_addr_reg;
  assign wr_data_o   = wr_data_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;

endmodule
